ram_burst_master: RTL and testbench

Bus-master front end for the team's single-port synchronous RAM (8-bit data, 8-bit address, CS/WE/RD strobes). It accepts burst commands on a valid/ready command port and streams write data in or read data out over valid/ready interfaces. It generates the CS/WE/RD/Addr/data signals the RAM expects, so client logic never drives the RAM strobes directly. It sits between datapath clients and the syncRAM instance.

---
 rtl/ram_burst_master.sv | 122 ++++++++++++
 tb/tb_ram_burst_master.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_master.sv
// ram_burst_master: turns valid/ready burst commands into CS/WE/RD strobe
// sequences for a single-port synchronous RAM. Writes stream one beat per
// accepted wr beat; reads take three cycles per beat (request, capture, offer).
module ram_burst_master #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int LW = 8
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          done,
    output logic          ram_cs,
    output logic          ram_we,
    output logic          ram_rd,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_CAP, RD_OUT, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cur_addr, cur_addr_nxt;
    logic [LW-1:0] beats_left, beats_left_nxt;
    logic [DW-1:0] rd_data_q, rd_data_q_nxt;

    // State register; reset drops any in-flight burst without a done pulse.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            cur_addr   <= '0;
            beats_left <= '0;
            rd_data_q  <= '0;
        end else begin
            state      <= state_nxt;
            cur_addr   <= cur_addr_nxt;
            beats_left <= beats_left_nxt;
            rd_data_q  <= rd_data_q_nxt;
        end
    end

    // Next-state and output decode; RAM strobes are only raised in WRITE
    // (gated by wr_valid) and RD_REQ, so WE and RD can never overlap.
    always_comb begin
        state_nxt      = state;
        cur_addr_nxt   = cur_addr;
        beats_left_nxt = beats_left;
        rd_data_q_nxt  = rd_data_q;
        cmd_ready      = 1'b0;
        wr_ready       = 1'b0;
        rd_valid       = 1'b0;
        done           = 1'b0;
        ram_cs         = 1'b0;
        ram_we         = 1'b0;
        ram_rd         = 1'b0;
        ram_addr       = '0;
        ram_wdata      = '0;
        rd_data        = rd_data_q;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cur_addr_nxt   = cmd_addr;
                    beats_left_nxt = cmd_len;
                    state_nxt      = cmd_write ? WRITE : RD_REQ;
                end
            end
            WRITE: begin
                wr_ready  = 1'b1;
                ram_cs    = wr_valid;
                ram_we    = wr_valid;
                ram_addr  = cur_addr;
                ram_wdata = wr_data;
                if (wr_valid) begin
                    cur_addr_nxt = cur_addr + 1'b1;
                    if (beats_left == '0) state_nxt = DONE;
                    else beats_left_nxt = beats_left - 1'b1;
                end
            end
            RD_REQ: begin
                ram_cs    = 1'b1;
                ram_rd    = 1'b1;
                ram_addr  = cur_addr;
                state_nxt = RD_CAP;
            end
            RD_CAP: begin
                // RAM output is valid the cycle after the CS&RD edge.
                rd_data_q_nxt = ram_rdata;
                state_nxt     = RD_OUT;
            end
            RD_OUT: begin
                rd_valid = 1'b1;
                if (rd_ready) begin
                    cur_addr_nxt = cur_addr + 1'b1;
                    if (beats_left == '0) begin
                        state_nxt = DONE;
                    end else begin
                        beats_left_nxt = beats_left - 1'b1;
                        state_nxt      = RD_REQ;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_burst_master.sv
// tb_ram_burst_master: directed plus randomized bursts against a behavioural
// sync-RAM and a flat reference memory holding what every address should hold.
module tb_ram_burst_master;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_data;
    logic       done;
    logic       ram_cs, ram_we, ram_rd;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];
    logic [7:0] bdata   [0:255];

    ram_burst_master dut (
        .Clk(Clk), .Rst(Rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_rd(ram_rd),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 Clk = ~Clk;

    // Behavioural single-port synchronous RAM.
    always @(posedge Clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_cs && ram_rd) ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Strobe legality every cycle: WE/RD exclusive, CS only with one of them.
    always @(negedge Clk) begin
        chk("we_rd_excl", {31'b0, ram_we & ram_rd}, 32'd0);
        chk("cs_iff_op", {31'b0, ram_cs}, {31'b0, ram_we | ram_rd});
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // gap: 0 = wr_valid always high, 1 = random, 2 = repeating 1,0,0,1
    task automatic run_write(input logic [7:0] a, input logic [7:0] len, input int gap);
        int beat = 0;
        int cyc = 0;
        logic v;
        logic [7:0] ea;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = len;
        #1;
        chk("wr_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        while (beat <= int'(len) && cyc < 3000) begin
            if (gap == 0) v = 1'b1;
            else if (gap == 1) v = 1'($urandom_range(0, 1));
            else v = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            wr_valid = v;
            wr_data = bdata[beat];
            #1;
            ea = a + 8'(beat);
            chk("wr_ready", {31'b0, wr_ready}, 32'd1);
            chk("wr_cs", {31'b0, ram_cs}, {31'b0, v});
            chk("wr_we", {31'b0, ram_we}, {31'b0, v});
            chk("wr_cmd_busy", {31'b0, cmd_ready}, 32'd0);
            if (v) begin
                chk("wr_addr", {24'b0, ram_addr}, {24'b0, ea});
                chk("wr_wdata", {24'b0, ram_wdata}, {24'b0, bdata[beat]});
                ref_mem[ea] = bdata[beat];
                beat++;
            end
            tick();
            cyc++;
        end
        chk("wr_budget", {31'b0, beat > int'(len)}, 32'd1);
        wr_valid = 1'b0;
        #1;
        chk("wr_done", {31'b0, done}, 32'd1);
        chk("wr_done_cs", {31'b0, ram_cs}, 32'd0);
        tick();
        chk("wr_done_once", {31'b0, done}, 32'd0);
        chk("wr_back_idle", {31'b0, cmd_ready}, 32'd1);
    endtask

    // stall: 0 = rd_ready always, 1 = random 0..3 stall cycles, 2 = 4 on beat 2
    task automatic run_read(input logic [7:0] a, input logic [7:0] len, input int stall);
        int ns;
        logic [7:0] ea;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = len;
        rd_ready = 1'b0;
        #1;
        chk("rd_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            ea = a + 8'(b);
            // request cycle
            chk("rd_req_cs", {31'b0, ram_cs}, 32'd1);
            chk("rd_req_rd", {31'b0, ram_rd}, 32'd1);
            chk("rd_req_addr", {24'b0, ram_addr}, {24'b0, ea});
            chk("rd_req_nvld", {31'b0, rd_valid}, 32'd0);
            tick();
            // capture cycle
            chk("rd_cap_cs", {31'b0, ram_cs}, 32'd0);
            chk("rd_cap_nvld", {31'b0, rd_valid}, 32'd0);
            tick();
            ns = (stall == 1) ? int'($urandom_range(0, 3)) : ((stall == 2 && b == 1) ? 4 : 0);
            for (int s = 0; s < ns; s++) begin
                chk("rd_stall_vld", {31'b0, rd_valid}, 32'd1);
                chk("rd_stall_data", {24'b0, rd_data}, {24'b0, ref_mem[ea]});
                chk("rd_stall_cs", {31'b0, ram_cs}, 32'd0);
                tick();
            end
            rd_ready = 1'b1;
            #1;
            chk("rd_vld", {31'b0, rd_valid}, 32'd1);
            chk("rd_data", {24'b0, rd_data}, {24'b0, ref_mem[ea]});
            chk("rd_out_cs", {31'b0, ram_cs}, 32'd0);
            tick();
            rd_ready = 1'b0;
        end
        chk("rd_done", {31'b0, done}, 32'd1);
        chk("rd_done_nvld", {31'b0, rd_valid}, 32'd0);
        chk("rd_hold", {24'b0, rd_data}, {24'b0, ref_mem[8'(a + len)]});
        tick();
        chk("rd_done_once", {31'b0, done}, 32'd0);
        chk("rd_back_idle", {31'b0, cmd_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] a, l;
        logic [7:0] d5 [0:4];
        logic [7:0] w4 [0:3];
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00; ref_mem[i] = 8'h00; bdata[i] = 8'h00;
        end
        ram_rdata = 8'h00;
        Rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        tick(); tick();
        Rst = 1'b0;
        #1;
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_ctrl", {26'b0, wr_ready, rd_valid, done, ram_cs, ram_we, ram_rd}, 32'd0);
        chk("rst_addr", {24'b0, ram_addr}, 32'd0);
        chk("rst_wdata", {24'b0, ram_wdata}, 32'd0);
        chk("rst_rdata", {24'b0, rd_data}, 32'd0);

        // Directed write then read-back at address 00.
        d5[0] = 8'h00; d5[1] = 8'h01; d5[2] = 8'h10; d5[3] = 8'h06; d5[4] = 8'h12;
        for (int i = 0; i < 5; i++) bdata[i] = d5[i];
        run_write(8'h00, 8'd4, 0);
        run_read(8'h00, 8'd4, 0);

        // Address wrap across FF -> 00.
        w4[0] = 8'hAA; w4[1] = 8'hBB; w4[2] = 8'hCC; w4[3] = 8'hDD;
        for (int i = 0; i < 4; i++) bdata[i] = w4[i];
        run_write(8'hFE, 8'd3, 0);
        run_read(8'hFE, 8'd3, 0);

        // Read backpressure on beat 2, then write with 1,0,0,1 valid gaps.
        run_read(8'h00, 8'd4, 2);
        for (int i = 0; i < 6; i++) bdata[i] = 8'($urandom);
        run_write(8'h40, 8'd5, 2);
        run_read(8'h40, 8'd5, 0);

        // Reset during beat 3 of a 5-beat write.
        for (int i = 0; i < 5; i++) bdata[i] = 8'($urandom);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h80; cmd_len = 8'd4;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1; wr_data = bdata[i];
            ref_mem[8'h80 + 8'(i)] = bdata[i];
            tick();
        end
        wr_valid = 1'b0;
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        #1;
        chk("mid_rst_ready", {31'b0, cmd_ready}, 32'd1);
        chk("mid_rst_strobes", {29'b0, ram_cs, ram_we, ram_rd}, 32'd0);
        chk("mid_rst_nodone", {31'b0, done}, 32'd0);
        chk("mid_rst_rdata", {24'b0, rd_data}, 32'd0);
        tick();
        chk("mid_rst_nodone2", {31'b0, done}, 32'd0);
        run_read(8'h80, 8'd1, 0);
        bdata[0] = 8'h5A;
        run_write(8'h82, 8'd0, 0);
        run_read(8'h80, 8'd2, 1);

        // Randomized bursts with random gaps and stalls.
        for (int n = 0; n < 12; n++) begin
            a = 8'($urandom);
            l = 8'($urandom_range(0, 15));
            for (int i = 0; i < 256; i++) bdata[i] = 8'($urandom);
            run_write(a, l, 1);
            run_read(a, l, 1);
        end

        // Full-length 256-beat burst.
        for (int i = 0; i < 256; i++) bdata[i] = 8'($urandom);
        run_write(8'h37, 8'hFF, 0);
        run_read(8'h37, 8'hFF, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
